// File: rtl/cdec8_ctrl_fsm.sv
// cdec8_ctrl_fsm: Moore-style microsequencer for the CDEC8 datapath.
// Steps through fetch / decode / operand fetch / execute for the 8-bit ISA
// and drives the 17-bit datapath control word.
//
// Ports:
//   clock    in   1   system clock, rising-edge active
//   reset_N  in   1   synchronous active-low reset
//   run      in   1   level; leaves IDLE when 1
//   I        in   8   instruction register from datapath
//   SZCy     in   3   flags {S,Z,Cy}
//   ctrl     out 17   {mmrw[1:0], fwr, rwr, xdst[3:0], aluop[4:0], xsrc[3:0]}
//   halted   out  1   1 in HALT or ILL
//   illegal  out  1   1 in ILL only
//   state    out  8   state code for the debug monitor
//
// All outputs decode directly from the registered state (and from I / SZCy
// in the execute states), so ctrl is valid for the whole cycle.
module cdec8_ctrl_fsm (
   input  logic        clock,
   input  logic        reset_N,
   input  logic        run,
   input  logic [7:0]  I,
   input  logic [2:0]  SZCy,
   output logic [16:0] ctrl,
   output logic        halted,
   output logic        illegal,
   output logic [7:0]  state
);

   localparam logic [4:0] ALU_ADD = 5'h01;
   localparam logic [4:0] ALU_SUB = 5'h02;
   localparam logic [4:0] ALU_AND = 5'h03;
   localparam logic [4:0] ALU_OR  = 5'h04;
   localparam logic [4:0] ALU_INC = 5'h08;

   // Transfer source / destination codes
   localparam logic [3:0] X_PC    = 4'h0;
   localparam logic [3:0] XS_R    = 4'h4;
   localparam logic [3:0] XD_MAR  = 4'h4;
   localparam logic [3:0] XS_RDR  = 4'h5;
   localparam logic [3:0] XD_WDR  = 4'h5;
   localparam logic [3:0] X_T     = 4'h6;
   localparam logic [3:0] XD_I    = 4'h7;
   localparam logic [3:0] XS_IPRT = 4'h8;
   localparam logic [3:0] XD_OPRT = 4'h8;
   localparam logic [3:0] X_IDLE  = 4'hF;

   localparam logic [1:0] MM_IDLE = 2'b00;
   localparam logic [1:0] MM_RD   = 2'b10;
   localparam logic [1:0] MM_WR   = 2'b01;

   typedef struct packed {
      logic [1:0] mmrw;
      logic       fwr;
      logic       rwr;
      logic [3:0] xdst;
      logic [4:0] aluop;
      logic [3:0] xsrc;
   } ctrl_t;

   localparam ctrl_t IDLE_WORD = '{mmrw: MM_IDLE, fwr: 1'b0, rwr: 1'b0,
                                   xdst: X_IDLE, aluop: 5'h00, xsrc: X_IDLE};

   typedef enum logic [3:0] {
      S_IDLE = 4'h0,
      S_F0   = 4'h1,
      S_F1   = 4'h2,
      S_F2   = 4'h3,
      S_F3   = 4'h4,
      S_DEC  = 4'h5,
      S_O0   = 4'h6,
      S_O1   = 4'h7,
      S_O2   = 4'h8,
      S_X0   = 4'h9,
      S_X1   = 4'hA,
      S_X2   = 4'hB,
      S_HALT = 4'hE,
      S_ILL  = 4'hF
   } state_t;

   state_t state_q;
   state_t state_d;
   ctrl_t  cw;

   // Instruction fields
   logic [3:0] cls;
   logic [3:0] reg_d;
   logic [3:0] reg_s;
   logic       d_ok;
   logic       s_ok;
   logic [4:0] alu_sel;
   logic       jmp_taken;

   assign cls   = I[7:4];
   assign reg_d = {2'b00, I[3:2]};
   assign reg_s = {2'b00, I[1:0]};
   assign d_ok  = (I[3:2] != 2'b00);
   assign s_ok  = (I[1:0] != 2'b00);

   // ALU opcode for classes 5..8
   always_comb begin
      alu_sel = 5'h00;
      case (cls)
         4'h5:    alu_sel = ALU_ADD;
         4'h6:    alu_sel = ALU_SUB;
         4'h7:    alu_sel = ALU_AND;
         4'h8:    alu_sel = ALU_OR;
         default: alu_sel = 5'h00;
      endcase
   end

   // Branch decision for JMP / JZ / JC / JS, using the live flags in X0
   always_comb begin
      jmp_taken = 1'b0;
      case (cls)
         4'h9:    jmp_taken = 1'b1;
         4'hA:    jmp_taken = SZCy[1];
         4'hB:    jmp_taken = SZCy[0];
         4'hC:    jmp_taken = SZCy[2];
         default: jmp_taken = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (!reset_N) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next state and control word
   always_comb begin
      state_d = state_q;
      cw      = IDLE_WORD;
      halted  = 1'b0;
      illegal = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_F0;
         end

         // Fetch; the operand fetch O0/O1/O2 reuses F0/F1/F3
         S_F0, S_O0: begin
            cw.xsrc = X_PC;
            cw.xdst = XD_MAR;
            state_d = (state_q == S_F0) ? S_F1 : S_O1;
         end
         S_F1, S_O1: begin
            cw.mmrw  = MM_RD;
            cw.xsrc  = X_PC;
            cw.aluop = ALU_INC;
            cw.rwr   = 1'b1;
            state_d  = (state_q == S_F1) ? S_F2 : S_O2;
         end
         S_F2: begin
            cw.xsrc = XS_RDR;
            cw.xdst = XD_I;
            state_d = S_F3;
         end
         S_F3, S_O2: begin
            cw.xsrc = XS_R;
            cw.xdst = X_PC;
            state_d = (state_q == S_F3) ? S_DEC : S_X0;
         end

         S_DEC: begin
            case (cls)
               4'h0: begin
                  if (I == 8'h00)      state_d = S_F0;
                  else if (I == 8'h01) state_d = S_HALT;
                  else                 state_d = S_ILL;
               end
               4'h1, 4'h5, 4'h6, 4'h7, 4'h8:
                  state_d = (d_ok && s_ok) ? S_X0 : S_ILL;
               4'h2, 4'h3, 4'h4:
                  state_d = s_ok ? S_O0 : S_ILL;
               4'h9, 4'hA, 4'hB, 4'hC:
                  state_d = S_O0;
               4'hD, 4'hE:
                  state_d = s_ok ? S_X0 : S_ILL;
               default:
                  state_d = S_ILL;
            endcase
         end

         S_X0: begin
            state_d = S_F0;
            case (cls)
               4'h1: begin
                  cw.xsrc = reg_s;
                  cw.xdst = reg_d;
               end
               4'h2: begin
                  cw.xsrc = XS_RDR;
                  cw.xdst = reg_s;
               end
               4'h3, 4'h4: begin
                  cw.xsrc = XS_RDR;
                  cw.xdst = XD_MAR;
                  state_d = S_X1;
               end
               4'h5, 4'h6, 4'h7, 4'h8: begin
                  cw.xsrc = reg_s;
                  cw.xdst = X_T;
                  state_d = S_X1;
               end
               4'h9, 4'hA, 4'hB, 4'hC: begin
                  // Not taken leaves the idle word: PC already points past the operand
                  if (jmp_taken) begin
                     cw.xsrc = XS_RDR;
                     cw.xdst = X_PC;
                  end
               end
               4'hD: begin
                  cw.xsrc = reg_s;
                  cw.xdst = XD_OPRT;
               end
               4'hE: begin
                  cw.xsrc = XS_IPRT;
                  cw.xdst = reg_s;
               end
               default: ;
            endcase
         end

         S_X1: begin
            state_d = S_X2;
            case (cls)
               4'h3: cw.mmrw = MM_RD;
               4'h4: begin
                  cw.xsrc = reg_s;
                  cw.xdst = XD_WDR;
               end
               4'h5, 4'h6, 4'h7, 4'h8: begin
                  cw.xsrc  = reg_d;
                  cw.aluop = alu_sel;
                  cw.rwr   = 1'b1;
                  cw.fwr   = 1'b1;
               end
               default: state_d = S_F0;
            endcase
         end

         S_X2: begin
            state_d = S_F0;
            case (cls)
               4'h3: begin
                  cw.xsrc = XS_RDR;
                  cw.xdst = reg_s;
               end
               4'h4: cw.mmrw = MM_WR;
               4'h5, 4'h6, 4'h7, 4'h8: begin
                  cw.xsrc = XS_R;
                  cw.xdst = reg_d;
               end
               default: ;
            endcase
         end

         // Sticky until reset
         S_HALT: begin
            halted = 1'b1;
         end
         S_ILL: begin
            halted  = 1'b1;
            illegal = 1'b1;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign ctrl  = cw;
   assign state = {4'h0, state_q};

endmodule

// File: doc/cdec8_ctrl_fsm.md
Name: cdec8_ctrl_fsm

Overview:
- Moore-style microsequencer driving the CDEC8 datapath's 17-bit ctrl bus from the fetched instruction (I) and the status flags (SZCy).
- Runs fetch / decode / operand-fetch / execute for a fixed 8-bit ISA, and exposes a state code for the PC debug monitor.
- ctrl field packing is {mmrw[1:0], fwr, rwr, xdst[3:0], aluop[4:0], xsrc[3:0]}.
- xsrc/xdst codes: PC=0, A=1, B=2, C=3, MAR=4 (dst) / R=4 (src), WDR=5 (dst) / RDR=5 (src), T=6, I=7 (dst), IPORT=8 (src), OPORT=8 (dst), idle=F.
- mmrw codes: 00 idle, 10 read (RDR<-data_in), 01 write strobe.

Parameters:
ALU_ADD, 5'h01, ALU opcode x+y
ALU_SUB, 5'h02, ALU opcode x-y
ALU_AND, 5'h03, ALU opcode x&y
ALU_OR, 5'h04, ALU opcode x|y
ALU_INC, 5'h08, ALU opcode x+1 (y ignored)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset_N  in  1  synchronous, active-low reset
run  in  1  level; leaves IDLE when 1
I  in  8  instruction register from datapath
SZCy  in  3  flags {S,Z,Cy} from datapath FLG
ctrl  out  17  datapath control word
halted  out  1  1 in HALT or ILL
illegal  out  1  1 in ILL only
state  out  8  state code for debug monitor (resource 0x0B)

Behaviour:
- ctrl, halted, illegal and state are combinational from the registered state (plus I and SZCy in the states noted below).
- "Idle word" = mmrw=00, fwr=0, rwr=0, xdst=F, aluop=00, xsrc=F. Every field not listed for a state takes its idle value.
- Reset (reset_N=0 at a rising edge): state<=IDLE. While in IDLE, ctrl is the idle word and halted=illegal=0. A reset asserted mid-instruction aborts it at that edge; no further ctrl strobes are issued.
- State codes:
  - IDLE=00, F0=01, F1=02, F2=03, F3=04, DEC=05
  - O0=06, O1=07, O2=08, X0=09, X1=0A, X2=0B
  - HALT=0E, ILL=0F
- IDLE: go to F0 when run=1, otherwise stay.
- Fetch sequence:
  - F0: xsrc=PC, xdst=MAR.
  - F1: mmrw=10; also xsrc=PC, aluop=ALU_INC, rwr=1. fwr stays 0, so flags are preserved.
  - F2: xsrc=RDR, xdst=I.
  - F3: xsrc=R, xdst=PC.
  - DEC: idle word.
- Operand fetch (2-byte instructions): O0/O1/O2 are identical to F0/F1/F3. After O2, RDR holds the operand and PC points past it; next state is X0.
- Field definitions:
  - cls = I[7:4]; d = I[3:2]; s = I[1:0]; r = I[1:0] (single-register forms).
  - Register codes 1=A, 2=B, 3=C. Code 0 in any used register field is illegal and DEC goes to ILL.
- Decode, per class (next state after the last listed step is F0 unless stated):
  - 0x0 NOP/HLT: I=00 goes DEC->F0. I=01 goes DEC->HALT. I=02..0F go to ILL.
  - 0x1 MOV d,s: X0: xsrc=s, xdst=d.
  - 0x2 LDI r,#imm: O0-O2, then X0: xsrc=RDR, xdst=r.
  - 0x3 LD r,[adr]: O0-O2, then X0: xsrc=RDR, xdst=MAR; X1: mmrw=10; X2: xsrc=RDR, xdst=r.
  - 0x4 ST r,[adr]: O0-O2, then X0: xsrc=RDR, xdst=MAR; X1: xsrc=r, xdst=WDR; X2: mmrw=01.
  - 0x5-0x8 ADD/SUB/AND/OR d,s (d <- d op s):
    - X0: xsrc=s, xdst=T.
    - X1: xsrc=d, aluop=op, rwr=1, fwr=1.
    - X2: xsrc=R, xdst=d.
  - 0x9 JMP adr: O0-O2, then X0: xsrc=RDR, xdst=PC.
  - 0xA JZ / 0xB JC / 0xC JS adr: O0-O2, then X0 tests Z=SZCy[1], Cy=SZCy[0], S=SZCy[2] respectively, sampled combinationally in X0.
    - Taken: same as JMP.
    - Not taken: idle word. PC already points to the next instruction.
  - 0xD OUT r: X0: xsrc=r, xdst=OPORT.
  - 0xE IN r: X0: xsrc=IPORT, xdst=r.
  - 0xF: ILL.
- HALT and ILL: idle word, halted=1 (illegal=1 in ILL only). Both are sticky until reset; run is ignored.
- Cycle counts from F0 to the next F0:
  - NOP, MOV, OUT, IN: 6 (5 for NOP).
  - LDI, JMP, Jcc: 9.
  - LD, ST: 11.
  - ALU ops: 8.
- Exactly one xdst target and at most one mmrw strobe per cycle, in every state.

Test Plan:
- Reset held 2 cycles with run=1 -> ctrl=idle word (mmrw=0, fwr=0, rwr=0, xdst=F, aluop=0, xsrc=F), state=00. Release reset -> state 01 on the next edge.
- I=8'h00 -> states 01,02,03,04,05,01; F1 ctrl has mmrw=10, rwr=1, aluop=08, xsrc=0, fwr=0.
- I=8'h21 (LDI A) -> after O2, X0 ctrl xsrc=5, xdst=1; 9 cycles total. I=8'h46 (MOV B? no: cls 4 = ST, r=2) -> X1 xsrc=2, xdst=5; X2 mmrw=01.
- I=8'h59 (ADD B,A) -> X0 xsrc=1, xdst=6; X1 xsrc=2, aluop=01, rwr=1, fwr=1; X2 xsrc=4, xdst=2.
- I=8'hA0 with SZCy=3'b010 -> X0 xsrc=5, xdst=0. With SZCy=3'b101 -> X0 idle word, next state 01.
- I=8'h01 -> HALT, halted=1, illegal=0, stays with run=1. I=8'h14 or 8'hF0 -> ILL, illegal=1. Reset recovers to IDLE.
